// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch state encoding, queue entry layout and PC helpers.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_entry_t;

    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {instr, pc4}; flush wins over any same-cycle push or pop.
module fetch_queue
    import pipe_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t entry_r [2];
    logic         rd_ptr_r;
    logic         wr_ptr_r;
    logic [1:0]   count_r;
    logic         push_ok_s;
    logic         pop_ok_s;
    logic [1:0]   count_next_s;

    // Qualify push/pop against occupancy and compute the next fill level.
    always_comb begin
        pop_ok_s  = pop & (count_r != 2'd0);
        push_ok_s = push & ((count_r != 2'd2) | pop_ok_s);
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_r[0] <= fetch_entry_t'(64'd0);
            entry_r[1] <= fetch_entry_t'(64'd0);
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
        end else if (flush) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                entry_r[wr_ptr_r] <= push_data;
                wr_ptr_r          <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_next_s;
        end
    end

    assign head  = entry_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues req/ack word fetches and feeds IF/ID
// from a 2-entry queue; an ID redirect squashes everything younger than the branch.
module if_fetch
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_D,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR_F_out,
    output logic [31:0] PC4_F_out,
    output logic        valid_F_out
);

    fetch_state_e state_r;
    logic [31:0]  pc_r;
    logic [31:0]  target_s;
    logic [31:0]  ack_pc4_s;
    logic         consume_s;
    logic         push_s;
    logic         room_s;
    logic [2:0]   fill_next_s;
    logic [1:0]   count_s;
    fetch_entry_t head_s;
    fetch_entry_t push_data_s;

    // Handshake qualifiers and head-of-queue presentation to IF/ID.
    always_comb begin
        target_s    = word_align(redirect_pc);
        ack_pc4_s   = next_word(imem_addr);
        valid_F_out = (count_s != 2'd0) & ~redirect;
        consume_s   = valid_F_out & ~stall_D;
        push_s      = (state_r == BUSY) & imem_ack & ~redirect;
        push_data_s = '{instr: imem_rdata, pc4: ack_pc4_s};
        // Room for one more fetch after this cycle's pop and push settle.
        fill_next_s = {1'b0, count_s} - {2'b00, consume_s} + {2'b00, push_s};
        room_s      = (fill_next_s < 3'd2);
        if (valid_F_out) begin
            IR_F_out  = head_s.instr;
            PC4_F_out = head_s.pc4;
        end else begin
            IR_F_out  = NOP_INSTR;
            PC4_F_out = 32'h0000_0000;
        end
    end

    fetch_queue u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (consume_s),
        .flush     (redirect),
        .push_data (push_data_s),
        .head      (head_s),
        .count     (count_s)
    );

    // Fetch FSM: PC, request and address; the address is frozen while a request is unacked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            pc_r      <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            case (state_r)
                IDLE: begin
                    if (redirect) begin
                        pc_r      <= target_s;
                        imem_addr <= target_s;
                        imem_req  <= 1'b1;
                        state_r   <= BUSY;
                    end else if (room_s) begin
                        imem_addr <= pc_r;
                        imem_req  <= 1'b1;
                        state_r   <= BUSY;
                    end else begin
                        imem_req <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                BUSY: begin
                    if (imem_ack && redirect) begin
                        pc_r      <= target_s;
                        imem_addr <= target_s;
                    end else if (redirect) begin
                        pc_r    <= target_s;
                        state_r <= FLUSH;
                    end else if (imem_ack) begin
                        pc_r <= ack_pc4_s;
                        if (room_s) begin
                            imem_addr <= ack_pc4_s;
                        end else begin
                            imem_req <= 1'b0;
                            state_r  <= IDLE;
                        end
                    end else begin
                        state_r <= BUSY;
                    end
                end
                // The stale request's data is dropped; the latest target is fetched next.
                FLUSH: begin
                    if (redirect) begin
                        pc_r <= target_s;
                        if (imem_ack) begin
                            imem_addr <= target_s;
                            state_r   <= BUSY;
                        end
                    end else if (imem_ack) begin
                        imem_addr <= pc_r;
                        state_r   <= BUSY;
                    end else begin
                        state_r <= FLUSH;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed and randomized bench for if_fetch against an in-order program-stream model.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk;
    logic        rst_n;
    logic        stall_D;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] IR_F_out;
    logic [31:0] PC4_F_out;
    logic        valid_F_out;

    if_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_D     (stall_D),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .IR_F_out    (IR_F_out),
        .PC4_F_out   (PC4_F_out),
        .valid_F_out (valid_F_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_err;
    int          n_checks;
    int          n_consumed;
    logic [31:0] exp_pc;
    logic        stall_v;
    logic        redir_v;
    logic [31:0] redir_pc_v;
    int          fix_lat;
    int          cur_lat;
    int          wait_cnt;
    bit          rand_lat;
    bit          prev_ok;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    logic [31:0] held;
    logic [31:0] a_pend;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory/ID inputs at negedge, then check against the stream model.
    task automatic step();
        @(negedge clk);
        if (rst_n && imem_req) begin
            if (wait_cnt >= cur_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = instr_of(imem_addr);
                wait_cnt   = 0;
                cur_lat    = rand_lat ? int'($urandom_range(0, 3)) : fix_lat;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wait_cnt++;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            wait_cnt   = 0;
        end
        stall_D     = stall_v;
        redirect    = redir_v;
        redirect_pc = redir_pc_v;
        #1;
        if (rst_n) begin
            if (redirect) chk("valid_on_redirect", 32'(valid_F_out), 32'd0);
            if (!valid_F_out) begin
                chk("ir_gated", IR_F_out, 32'd0);
                chk("pc4_gated", PC4_F_out, 32'd0);
            end else if (!stall_D && !redirect) begin
                chk("stream_pc4", PC4_F_out, exp_pc + 32'd4);
                chk("stream_ir", IR_F_out, instr_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
            if (redirect) exp_pc = redirect_pc;
            if (imem_req) chk("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
            if (prev_ok && prev_req && !prev_ack) begin
                chk("req_held", 32'(imem_req), 32'd1);
                chk("addr_held", imem_addr, prev_addr);
            end
        end
        prev_ok   = rst_n;
        prev_req  = imem_req;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
    endtask

    initial begin
        n_err = 0; n_checks = 0; n_consumed = 0;
        exp_pc = RST_PC;
        stall_v = 1'b0; redir_v = 1'b0; redir_pc_v = 32'd0;
        fix_lat = 0; cur_lat = 0; wait_cnt = 0; rand_lat = 1'b0;
        prev_ok = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'd0;
        rst_n = 1'b0; stall_D = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_ack = 1'b0; imem_rdata = 32'd0;

        // Reset state
        step(); step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", 32'(valid_F_out), 32'd0);
        chk("rst_ir", IR_F_out, 32'd0);
        chk("rst_pc4", PC4_F_out, 32'd0);
        rst_n = 1'b1;

        // Zero-wait streaming: one fetch and one delivery per cycle
        step(); chk("zw_req0", 32'(imem_req), 32'd1); chk("zw_addr0", imem_addr, 32'h0000_3000);
        step(); chk("zw_addr1", imem_addr, 32'h0000_3004); chk("zw_pc4_0", PC4_F_out, 32'h0000_3004);
        step(); chk("zw_addr2", imem_addr, 32'h0000_3008); chk("zw_pc4_1", PC4_F_out, 32'h0000_3008);
        for (int i = 0; i < 5; i++) step();

        // Stall fills the queue, request drops, head is held
        stall_v = 1'b1;
        step(); held = PC4_F_out;
        step(); step(); step();
        chk("stall_req_drop", 32'(imem_req), 32'd0);
        chk("stall_head_held", PC4_F_out, held);
        chk("stall_valid", 32'(valid_F_out), 32'd1);
        stall_v = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // Three-cycle ack latency keeps the request stable
        fix_lat = 2; cur_lat = 2;
        for (int i = 0; i < 10; i++) begin
            if (imem_req && !imem_ack && wait_cnt == 1) break;
            step();
        end
        chk("lat_found", 32'(imem_req && !imem_ack && wait_cnt == 1), 32'd1);
        a_pend = imem_addr;
        step(); chk("lat_addr1", imem_addr, a_pend);
        step(); chk("lat_addr2", imem_addr, a_pend);
        for (int i = 0; i < 15; i++) step();

        // Redirect with a full queue and a pending request goes through FLUSH
        fix_lat = 0; cur_lat = 0; stall_v = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!imem_req) break;
            step();
        end
        chk("fill_req_drop", 32'(imem_req), 32'd0);
        fix_lat = 4; cur_lat = 4; stall_v = 1'b0;
        step();
        stall_v = 1'b1;
        step();
        chk("pend_req", 32'(imem_req), 32'd1);
        a_pend = imem_addr;
        redir_v = 1'b1; redir_pc_v = 32'h0000_3100;
        step();
        redir_v = 1'b0; stall_v = 1'b0;
        step();
        chk("flush_req", 32'(imem_req), 32'd1);
        chk("flush_addr", imem_addr, a_pend);
        for (int i = 0; i < 30; i++) begin
            if (valid_F_out) break;
            step();
        end
        chk("redir_first_valid", 32'(valid_F_out), 32'd1);
        chk("redir_first_pc4", PC4_F_out, 32'h0000_3104);

        // Redirect coinciding with an ack drops the data
        fix_lat = 0; cur_lat = 0;
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 5; i++) begin
            if (imem_req) break;
            step();
        end
        redir_v = 1'b1; redir_pc_v = 32'h0000_4000;
        step();
        redir_v = 1'b0;
        step();
        chk("ra_addr", imem_addr, 32'h0000_4000);
        chk("ra_req", 32'(imem_req), 32'd1);
        chk("ra_empty", 32'(valid_F_out), 32'd0);
        step();
        chk("ra_pc4", PC4_F_out, 32'h0000_4004);

        // Asynchronous reset in the middle of a request
        fix_lat = 3; cur_lat = 3;
        for (int i = 0; i < 10; i++) begin
            if (imem_req && !imem_ack) break;
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_valid", 32'(valid_F_out), 32'd0);
        chk("arst_ir", IR_F_out, 32'd0);
        chk("arst_pc4", PC4_F_out, 32'd0);
        chk("arst_addr", imem_addr, RST_PC);
        step();
        rst_n = 1'b1;
        exp_pc = RST_PC;
        step();
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_addr", imem_addr, RST_PC);

        // Randomized stalls, redirects (including near the wrap) and latencies
        rand_lat = 1'b1;
        n_consumed = 0;
        for (int i = 0; i < 800; i++) begin
            stall_v = ($urandom_range(0, 3) == 0);
            redir_v = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                redir_pc_v = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
            else
                redir_pc_v = $urandom & 32'hFFFF_FFFC;
            step();
        end
        redir_v = 1'b0; stall_v = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("progress", 32'(n_consumed > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
